// File: rtl/sweep_pkg.sv
// ============================================================
// sweep_pkg: shared types for the triangle sweep sequencer
// Rev 1.0
// ============================================================
`default_nettype none

package sweep_pkg;

  localparam int unsigned CYCLE_W = 8;

  typedef enum logic [1:0] {
    MODE_ONESHOT    = 2'd0,
    MODE_NCYCLES    = 2'd1,
    MODE_CONTINUOUS = 2'd2
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // The unused encoding 3 folds onto ONESHOT.
  function automatic mode_t decode_mode(input logic [1:0] raw);
    case (raw)
      2'd1:    decode_mode = MODE_NCYCLES;
      2'd2:    decode_mode = MODE_CONTINUOUS;
      default: decode_mode = MODE_ONESHOT;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/step_prescaler.sv
// ============================================================
// step_prescaler: emits one tick every period+1 cycles
// Rev 1.0
// ============================================================
`default_nettype none

module step_prescaler #(
  parameter int PRESCALE_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic [PRESCALE_W-1:0] period,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] count_q;
  logic [PRESCALE_W-1:0] count_d;

  always_comb begin
    tick    = !clear && (count_q == period);
    count_d = count_q + 1'b1;
    if (clear || tick) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/sweep_controller.sv
// ============================================================
// sweep_controller: runs a triangle counter for one, N or endless sweeps
// Rev 1.0
// ============================================================
`default_nettype none

module sweep_controller
  import sweep_pkg::*;
#(
  parameter int N          = 8,
  parameter int PRESCALE_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stop,
  input  logic [1:0]            mode,
  input  logic [CYCLE_W-1:0]    cycles,
  input  logic [PRESCALE_W-1:0] period,
  input  logic [N-1:0]          level,
  output logic                  gen_ena,
  output logic                  gen_rst,
  output logic                  busy,
  output logic                  done,
  output logic [CYCLE_W-1:0]    cycle_count
);

  state_t                state_q, state_d;
  mode_t                 mode_q, mode_d;
  logic [CYCLE_W-1:0]    cycles_q, cycles_d;
  logic [PRESCALE_W-1:0] period_q, period_d;
  logic                  seen_max_q, seen_max_d;
  logic [CYCLE_W-1:0]    cycle_count_q, cycle_count_d;

  logic               tick;
  logic               level_max;
  logic               level_zero;
  logic               sweep_done;
  logic               run_ends;
  logic [CYCLE_W-1:0] count_inc;
  logic [CYCLE_W-1:0] count_target;

  step_prescaler #(
    .PRESCALE_W(PRESCALE_W)
  ) u_prescaler (
    .clk   (clk),
    .rst   (rst),
    .clear (state_q != ST_RUN),
    .period(period_q),
    .tick  (tick)
  );

  assign level_max    = (level == {N{1'b1}});
  assign level_zero   = (level == '0);
  assign sweep_done   = seen_max_q && level_zero;
  assign count_inc    = (cycle_count_q == {CYCLE_W{1'b1}}) ? cycle_count_q : cycle_count_q + 1'b1;
  assign count_target = (cycles_q == '0) ? CYCLE_W'(1) : cycles_q;

  // CONTINUOUS matches neither term, so it only ends on stop.
  assign run_ends = sweep_done &&
                    ((mode_q == MODE_ONESHOT) ||
                     ((mode_q == MODE_NCYCLES) && (count_inc >= count_target)));

  always_comb begin
    state_d       = state_q;
    mode_d        = mode_q;
    cycles_d      = cycles_q;
    period_d      = period_q;
    seen_max_d    = seen_max_q;
    cycle_count_d = cycle_count_q;
    gen_ena       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start && !stop) begin
          mode_d   = decode_mode(mode);
          cycles_d = cycles;
          period_d = period;
          state_d  = ST_ARM;
        end
      end
      ST_ARM: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else begin
          seen_max_d    = 1'b0;
          cycle_count_d = '0;
          state_d       = ST_RUN;
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else begin
          if (sweep_done) begin
            seen_max_d    = 1'b0;
            cycle_count_d = count_inc;
          end else if (level_max) begin
            seen_max_d = 1'b1;
          end
          // Suppressing the final step parks the counter at 0.
          if (run_ends) begin
            state_d = ST_DONE;
          end else begin
            gen_ena = tick;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      mode_q        <= MODE_ONESHOT;
      cycles_q      <= '0;
      period_q      <= '0;
      seen_max_q    <= 1'b0;
      cycle_count_q <= '0;
    end else begin
      state_q       <= state_d;
      mode_q        <= mode_d;
      cycles_q      <= cycles_d;
      period_q      <= period_d;
      seen_max_q    <= seen_max_d;
      cycle_count_q <= cycle_count_d;
    end
  end

  assign gen_rst     = rst || (state_q == ST_ARM);
  assign busy        = (state_q == ST_ARM) || (state_q == ST_RUN);
  assign done        = (state_q == ST_DONE);
  assign cycle_count = cycle_count_q;

endmodule

`default_nettype wire

// File: tb/tb_sweep_controller.sv
// ============================================================
// tb_sweep_controller: directed bench with ideal triangle counters
// Rev 1.0
// ============================================================
`default_nettype none

module tb_sweep_controller;

  localparam int NA = 3;
  localparam int NB = 2;
  localparam int PW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic          a_start, a_stop;
  logic [1:0]    a_mode;
  logic [7:0]    a_cycles;
  logic [PW-1:0] a_period;
  logic [NA-1:0] a_level;
  logic          a_up;
  logic          a_gen_ena, a_gen_rst, a_busy, a_done;
  logic [7:0]    a_cycle_count;

  logic          b_start, b_stop;
  logic [1:0]    b_mode;
  logic [7:0]    b_cycles;
  logic [PW-1:0] b_period;
  logic [NB-1:0] b_level;
  logic          b_up;
  logic          b_gen_ena, b_gen_rst, b_busy, b_done;
  logic [7:0]    b_cycle_count;

  sweep_controller #(.N(NA), .PRESCALE_W(PW)) dut_a (
    .clk(clk), .rst(rst), .start(a_start), .stop(a_stop), .mode(a_mode),
    .cycles(a_cycles), .period(a_period), .level(a_level),
    .gen_ena(a_gen_ena), .gen_rst(a_gen_rst), .busy(a_busy), .done(a_done),
    .cycle_count(a_cycle_count)
  );

  sweep_controller #(.N(NB), .PRESCALE_W(PW)) dut_b (
    .clk(clk), .rst(rst), .start(b_start), .stop(b_stop), .mode(b_mode),
    .cycles(b_cycles), .period(b_period), .level(b_level),
    .gen_ena(b_gen_ena), .gen_rst(b_gen_rst), .busy(b_busy), .done(b_done),
    .cycle_count(b_cycle_count)
  );

  // Ideal triangle counters: reset to 0 counting up, turn at 0 and max.
  always @(posedge clk) begin
    if (a_gen_rst) begin
      a_level <= '0;
      a_up    <= 1'b1;
    end else if (a_gen_ena) begin
      if (a_up) begin
        if (a_level == {NA{1'b1}}) begin a_level <= a_level - 1'b1; a_up <= 1'b0; end
        else a_level <= a_level + 1'b1;
      end else begin
        if (a_level == '0) begin a_level <= a_level + 1'b1; a_up <= 1'b1; end
        else a_level <= a_level - 1'b1;
      end
    end
  end

  always @(posedge clk) begin
    if (b_gen_rst) begin
      b_level <= '0;
      b_up    <= 1'b1;
    end else if (b_gen_ena) begin
      if (b_up) begin
        if (b_level == {NB{1'b1}}) begin b_level <= b_level - 1'b1; b_up <= 1'b0; end
        else b_level <= b_level + 1'b1;
      end else begin
        if (b_level == '0) begin b_level <= b_level + 1'b1; b_up <= 1'b1; end
        else b_level <= b_level - 1'b1;
      end
    end
  end

  int a_ena_cnt  = 0;
  int a_done_cnt = 0;
  int b_done_cnt = 0;
  always @(posedge clk) begin
    if (a_gen_ena) a_ena_cnt <= a_ena_cnt + 1;
    if (a_done)    a_done_cnt <= a_done_cnt + 1;
    if (b_done)    b_done_cnt <= b_done_cnt + 1;
  end

  int checks = 0;
  int errors = 0;
  int base_ena, base_done, base_b_done;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    a_start = 1'b0; a_stop = 1'b0; a_mode = 2'd0; a_cycles = 8'd0; a_period = '0;
    b_start = 1'b0; b_stop = 1'b0; b_mode = 2'd0; b_cycles = 8'd0; b_period = '0;

    // Reset state
    adv; adv; smp;
    check("rst_gen_rst", 32'(a_gen_rst), 1);
    check("rst_gen_ena", 32'(a_gen_ena), 0);
    check("rst_busy", 32'(a_busy), 0);
    check("rst_done", 32'(a_done), 0);
    check("rst_cycle_count", 32'(a_cycle_count), 0);
    check("rst_b_gen_rst", 32'(b_gen_rst), 1);
    adv; rst = 1'b0; smp;
    check("idle_gen_rst", 32'(a_gen_rst), 0);

    // ONESHOT, period 0: 14 back-to-back steps, done at t+17
    adv;
    a_mode = 2'd0; a_period = 16'd0; a_cycles = 8'd0; a_start = 1'b1;
    base_ena = a_ena_cnt; base_done = a_done_cnt;
    adv; a_start = 1'b0; smp;
    check("t1_arm_busy", 32'(a_busy), 1);
    check("t1_arm_gen_rst", 32'(a_gen_rst), 1);
    check("t1_arm_gen_ena", 32'(a_gen_ena), 0);
    for (int k = 2; k <= 17; k++) begin
      adv; smp;
      check("t1_gen_ena", 32'(a_gen_ena), 32'(k <= 15));
      check("t1_done", 32'(a_done), 32'(k == 17));
      check("t1_busy", 32'(a_busy), 32'(k <= 16));
    end
    check("t1_cycle_count", 32'(a_cycle_count), 1);
    check("t1_level", 32'(a_level), 0);
    adv; smp;
    check("t1_steps", 32'(a_ena_cnt - base_ena), 14);
    check("t1_done_count", 32'(a_done_cnt - base_done), 1);
    check("t1_idle_busy", 32'(a_busy), 0);

    // NCYCLES=3, period 2, with an ignored start and config change mid-run
    adv;
    a_mode = 2'd1; a_cycles = 8'd3; a_period = 16'd2; a_start = 1'b1;
    base_ena = a_ena_cnt; base_done = a_done_cnt;
    adv; a_start = 1'b0;
    for (int k = 2; k <= 129; k++) begin
      adv;
      if (k == 50) begin
        a_start = 1'b1; a_mode = 2'd0; a_period = 16'd0; a_cycles = 8'd1;
      end else if (k == 51) begin
        a_start = 1'b0;
      end
      smp;
      check("t2_gen_ena", 32'(a_gen_ena), 32'((k >= 4) && (k <= 127) && (((k - 4) % 3) == 0)));
      check("t2_done", 32'(a_done), 32'(k == 129));
      check("t2_busy", 32'(a_busy), 32'(k <= 128));
    end
    check("t2_cycle_count", 32'(a_cycle_count), 3);
    adv; smp;
    check("t2_steps", 32'(a_ena_cnt - base_ena), 42);
    check("t2_done_count", 32'(a_done_cnt - base_done), 1);
    check("t2_level", 32'(a_level), 0);
    check("t2_idle_busy", 32'(a_busy), 0);

    // start and stop together in IDLE: no run begins
    adv; a_start = 1'b1; a_stop = 1'b1; a_mode = 2'd0; a_period = 16'd0;
    base_done = a_done_cnt;
    adv; a_start = 1'b0; a_stop = 1'b0; smp;
    check("ss_busy", 32'(a_busy), 0);
    check("ss_gen_rst", 32'(a_gen_rst), 0);
    adv; smp;
    check("ss_busy2", 32'(a_busy), 0);
    check("ss_gen_ena", 32'(a_gen_ena), 0);
    adv; adv; smp;
    check("ss_no_done", 32'(a_done_cnt - base_done), 0);

    // Reset in the middle of a NCYCLES=2 run after one sweep
    adv; a_mode = 2'd1; a_cycles = 8'd2; a_period = 16'd0; a_start = 1'b1;
    adv; a_start = 1'b0;
    for (int k = 2; k <= 20; k++) adv;
    smp;
    check("mr_busy", 32'(a_busy), 1);
    check("mr_cycle_count", 32'(a_cycle_count), 1);
    adv; rst = 1'b1; smp;
    check("mr_gen_rst", 32'(a_gen_rst), 1);
    adv; rst = 1'b0; smp;
    check("mr_busy_after", 32'(a_busy), 0);
    check("mr_done_after", 32'(a_done), 0);
    check("mr_gen_ena_after", 32'(a_gen_ena), 0);
    check("mr_gen_rst_after", 32'(a_gen_rst), 0);
    check("mr_cycle_count_after", 32'(a_cycle_count), 0);
    check("mr_level_after", 32'(a_level), 0);

    // NCYCLES with cycles=0 behaves as a single sweep
    adv; a_mode = 2'd1; a_cycles = 8'd0; a_period = 16'd0; a_start = 1'b1;
    base_ena = a_ena_cnt; base_done = a_done_cnt;
    adv; a_start = 1'b0;
    for (int k = 2; k <= 17; k++) begin
      adv; smp;
      check("t6_done", 32'(a_done), 32'(k == 17));
      check("t6_busy", 32'(a_busy), 32'(k <= 16));
    end
    check("t6_cycle_count", 32'(a_cycle_count), 1);
    adv; smp;
    check("t6_steps", 32'(a_ena_cnt - base_ena), 14);
    check("t6_done_count", 32'(a_done_cnt - base_done), 1);
    check("t6_level", 32'(a_level), 0);

    // CONTINUOUS on the 2-bit counter, stopped in cycle t+100
    adv; b_mode = 2'd2; b_period = 16'd0; b_cycles = 8'd0; b_start = 1'b1;
    base_b_done = b_done_cnt;
    adv; b_start = 1'b0;
    for (int k = 2; k <= 99; k++) adv;
    adv; b_stop = 1'b1; smp;
    check("cs_stop_gen_ena", 32'(b_gen_ena), 0);
    check("cs_stop_busy", 32'(b_busy), 1);
    check("cs_stop_cycle_count", 32'(b_cycle_count), 16);
    check("cs_stop_level", 32'(b_level), 2);
    adv; b_stop = 1'b0; smp;
    check("cs_busy_after", 32'(b_busy), 0);
    check("cs_done_after", 32'(b_done), 0);
    check("cs_level_frozen", 32'(b_level), 2);
    check("cs_cycle_count_kept", 32'(b_cycle_count), 16);
    adv; adv; smp;
    check("cs_level_frozen2", 32'(b_level), 2);
    check("cs_no_done", 32'(b_done_cnt - base_b_done), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
